period_meter: RTL and testbench

- Receive-side counterpart to the clock divider: takes a slow, divided, toggling signal (e.g. the divider's led output) and measures it.
- Synchronises the signal into clk and detects its edges.
- Reports the period and high time in clk cycles, with a one-cycle valid strobe per measurement.
- Flags loss of signal when no rising edge arrives within a timeout.
- Used on-chip and in benches to check divider ratio and duty cycle.

---
 rtl/period_meter.sv | 156 +++++++++++++++
 tb/tb_period_meter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Period / high-time meter for a slow toggling signal.
// Synchronises sig_in, detects edges, measures rising-to-rising and
// rising-to-falling intervals in clk cycles and flags loss of signal.
// Optional build macro PERIOD_METER_AVG_EN: report the truncated mean of
// every four consecutive measurements instead of each one.
module period_meter #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 2**24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             nosig_q, nosig_d;

`ifdef PERIOD_METER_AVG_EN
    logic [CNT_W+1:0] acc_p_q, acc_p_d;
    logic [CNT_W+1:0] acc_h_q, acc_h_d;
    logic [CNT_W+1:0] sum_p, sum_h;
    logic [1:0]       idx_q, idx_d;

    assign sum_p = acc_p_q + {2'b00, counter_q};
    assign sum_h = acc_h_q + {2'b00, hi_q};
`endif

    // Both edges see the same synchroniser depth, so intervals are exact.
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Next-state, counter and measurement update logic.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        hi_d      = hi_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        nosig_d   = nosig_q;
`ifdef PERIOD_METER_AVG_EN
        acc_p_d   = acc_p_q;
        acc_h_d   = acc_h_q;
        idx_d     = idx_q;
`endif
        unique case (state_q)
            StIdle: begin
                counter_d = '0;
                // First rise only arms the measurement.
                if (rise) begin
                    counter_d = CntOne;
                    state_d   = StMeasure;
                    nosig_d   = 1'b0;
                end
            end
            StMeasure: begin
                counter_d = counter_q + CntOne;
                if (fall) begin
                    hi_d = counter_q;
                end
                // A rise on the timeout cycle still counts as a measurement.
                if (rise) begin
                    counter_d = CntOne;
`ifdef PERIOD_METER_AVG_EN
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        period_d = sum_p[CNT_W+1:2];
                        high_d   = sum_h[CNT_W+1:2];
                        valid_d  = 1'b1;
                        acc_p_d  = '0;
                        acc_h_d  = '0;
                    end else begin
                        acc_p_d  = sum_p;
                        acc_h_d  = sum_h;
                    end
`else
                    period_d = counter_q;
                    high_d   = hi_q;
                    valid_d  = 1'b1;
`endif
                end else if (counter_q == TimeoutVal) begin
                    state_d   = StIdle;
                    nosig_d   = 1'b1;
                    counter_d = '0;
`ifdef PERIOD_METER_AVG_EN
                    idx_d   = 2'd0;
                    acc_p_d = '0;
                    acc_h_d = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            counter_q <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            nosig_q   <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
            acc_p_q   <= '0;
            acc_h_q   <= '0;
            idx_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            s1_q      <= sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            counter_q <= counter_d;
            hi_q      <= hi_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            nosig_q   <= nosig_d;
`ifdef PERIOD_METER_AVG_EN
            acc_p_q   <= acc_p_d;
            acc_h_q   <= acc_h_d;
            idx_q     <= idx_d;
`endif
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign no_signal  = nosig_q;
    assign busy       = (state_q == StMeasure);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a queue-based scoreboard.
// Expected measurements are pushed at each driven rising edge and popped
// by a monitor whenever meas_valid strobes.
module tb_period_meter;

    localparam int unsigned CW = 16;
    localparam int unsigned TO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          sig_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          no_signal;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_q[$];
    int  prev_hi = 0, prev_lo = 0;
    bit  armed = 0;
    int  acc_p = 0, acc_h = 0, idx = 0;
    int  last_p = 0, last_h = 0;
    bit  last_v = 0;

    period_meter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .no_signal  (no_signal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model of what the meter reports for one completed period.
    task automatic push_meas(input int p, input int h);
`ifdef PERIOD_METER_AVG_EN
        acc_p += p;
        acc_h += h;
        idx++;
        if (idx == 4) begin
            last_p = acc_p / 4;
            last_h = acc_h / 4;
            sb_q.push_back({last_p[15:0], last_h[15:0]});
            acc_p = 0;
            acc_h = 0;
            idx = 0;
        end
`else
        last_p = p;
        last_h = h;
        sb_q.push_back({last_p[15:0], last_h[15:0]});
`endif
    endtask

    task automatic clear_model();
        armed = 0;
        acc_p = 0;
        acc_h = 0;
        idx = 0;
    endtask

    task automatic pulse(input int hi, input int lo);
        sig_in = 1'b1;
        if (armed) push_meas(prev_hi + prev_lo, prev_hi);
        armed = 1;
        prev_hi = hi;
        prev_lo = lo;
        repeat (hi) @(negedge clk);
        sig_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (meas_valid) begin
            check("valid_single_cycle", {31'd0, last_v}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {16'd0, period}, 32'hFFFF_FFFF);
            end else begin
                check("meas_period_high", {period, high_time}, sb_q.pop_front());
            end
        end
        last_v = meas_valid;
    end

    initial begin
        int n;
        bit seen;
        rst = 1'b0;
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_period", {16'd0, period}, 32'd0);
        check("rst_high", {16'd0, high_time}, 32'd0);
        check("rst_valid", {31'd0, meas_valid}, 32'd0);
        check("rst_nosig", {31'd0, no_signal}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Square wave 8/8: first rise arms only.
        for (int i = 0; i < 5; i++) pulse(8, 8);
        check("busy_measuring", {31'd0, busy}, 32'd1);
        // Duty change 3/7.
        for (int i = 0; i < 4; i++) pulse(3, 7);

        // Last rise then hold low until timeout.
        pulse(3, 0);
        n = 3;
        seen = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (no_signal) seen = 1;
        end
        check("timeout_latency", n, 32'd103);
        check("timeout_nosig", {31'd0, no_signal}, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_keep_period", {16'd0, period}, last_p);
        check("timeout_keep_high", {16'd0, high_time}, last_h);
        clear_model();
        pulse(8, 8);
        check("rearm_nosig_clear", {31'd0, no_signal}, 32'd0);
        check("rearm_busy", {31'd0, busy}, 32'd1);
        pulse(8, 8);
        pulse(5, 5);

        // Reset mid-period.
        pulse(4, 3);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_period", {16'd0, period}, 32'd0);
        check("midrst_high", {16'd0, high_time}, 32'd0);
        check("midrst_valid", {31'd0, meas_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) pulse(6, 4);

        // sig_in held high through reset release: release acts as the arming rise.
        sig_in = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("hirst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        clear_model();
        pulse(10, 6);
        pulse(10, 6);
        pulse(4, 4);
        for (int i = 0; i < 6; i++) pulse(7, 5);

        repeat (12) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
